// File: rtl/pc_seq_if.sv
// Request/response bundle between a program-counter client and pc_seq.
// The master drives the requests and observes the program counter and stack flags.
`timescale 1ns/1ps
interface pc_seq_if #(
    parameter int ADDR_W = 8
);
    logic              en;
    logic              branch_sel;
    logic [ADDR_W-1:0] branch_off;
    logic              jump_sel;
    logic [ADDR_W-1:0] jump_addr;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] pc_out;
    logic              ras_full;
    logic              ras_empty;
    logic              ras_err;

    modport master (
        output en, branch_sel, branch_off, jump_sel, jump_addr, call, ret,
        input  pc_out, ras_full, ras_empty, ras_err
    );

    modport slave (
        input  en, branch_sel, branch_off, jump_sel, jump_addr, call, ret,
        output pc_out, ras_full, ras_empty, ras_err
    );
endinterface

// File: rtl/pc_seq.sv
// Program-counter sequencer: increment, relative branch, absolute jump, call/return.
// Define PC_SEQ_RAS_EN to build in the return-address stack; otherwise call acts as jump and ret is ignored.
`timescale 1ns/1ps
module pc_seq #(
    parameter int               ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    pc_seq_if.slave  bus
);
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_flow;

    assign pc_inc = pc_q + ADDR_W'(1);

    // Next pc for the non-stack requests; the offset has full width, so modulo add is the sign extension.
    always_comb begin
        pc_flow = pc_inc;
        if (bus.jump_sel) begin
            pc_flow = bus.jump_addr;
        end else if (bus.branch_sel) begin
            pc_flow = pc_q + bus.branch_off;
        end
    end

`ifdef PC_SEQ_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              push;
    logic              ras_full_w;
    logic              ras_empty_w;
    logic [ADDR_W-1:0] ras_top;

    assign ras_full_w  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_empty_w = (cnt_q == '0);
    assign ras_top     = ras_mem[cnt_q[PTR_W-1:0] - PTR_W'(1)];

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        err_d = err_q;
        push  = 1'b0;
        if (bus.en) begin
            if (bus.ret) begin
                if (ras_empty_w) begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end else begin
                    pc_d  = ras_top;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (bus.call) begin
                pc_d = bus.jump_addr;
                if (ras_full_w) begin
                    err_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                pc_d = pc_flow;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_VEC;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Storage is deliberately unreset: entries are only read below the live count.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[cnt_q[PTR_W-1:0]] <= pc_inc;
        end
    end

    assign bus.ras_full  = ras_full_w;
    assign bus.ras_empty = ras_empty_w;
    assign bus.ras_err   = err_q;
`else
    always_comb begin
        pc_d = pc_q;
        if (bus.en) begin
            pc_d = bus.call ? bus.jump_addr : pc_flow;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.ras_full  = 1'b0;
    assign bus.ras_empty = 1'b1;
    assign bus.ras_err   = 1'b0;
`endif

    assign bus.pc_out = pc_q;
endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq (ADDR_W=8, RESET_VEC=8'h10, RAS_DEPTH=4); expectations follow PC_SEQ_RAS_EN.
`timescale 1ns/1ps
module tb_pc_seq;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    pc_seq_if #(.ADDR_W(8)) bus ();

    pc_seq #(.ADDR_W(8), .RESET_VEC(8'h10), .RAS_DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        logic       full;
        logic       empty;
        logic       err;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] stk[$];
    logic [7:0] pc_m;
    logic       err_m;
    int         n_vec = 0;
    int         n_err = 0;
    int         n_txn = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic m_full();
`ifdef PC_SEQ_RAS_EN
        return stk.size() == 4;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_empty();
`ifdef PC_SEQ_RAS_EN
        return stk.size() == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        pc_m  = 8'h10;
        err_m = 1'b0;
        stk.delete();
    endtask

    task automatic model_step(input logic en, input logic ret, input logic call,
                              input logic jmp, input logic br,
                              input logic [7:0] off, input logic [7:0] addr);
        if (!en) return;
`ifdef PC_SEQ_RAS_EN
        if (ret) begin
            if (stk.size() == 0) begin
                pc_m  = pc_m + 8'd1;
                err_m = 1'b1;
            end else begin
                pc_m = stk.pop_back();
            end
        end else if (call) begin
            if (stk.size() == 4) err_m = 1'b1;
            else stk.push_back(pc_m + 8'd1);
            pc_m = addr;
        end else if (jmp) pc_m = addr;
        else if (br) pc_m = pc_m + off;
        else pc_m = pc_m + 8'd1;
`else
        if (call || jmp) pc_m = addr;
        else if (br) pc_m = pc_m + off;
        else pc_m = pc_m + 8'd1;
`endif
    endtask

    task automatic compare_outputs(input string name, input exp_t e);
        check({name, ".pc"},    32'(bus.pc_out),    32'(e.pc));
        check({name, ".full"},  32'(bus.ras_full),  32'(e.full));
        check({name, ".empty"}, 32'(bus.ras_empty), 32'(e.empty));
        check({name, ".err"},   32'(bus.ras_err),   32'(e.err));
    endtask

    // Drive one request, queue its expected result, then compare after the next rising edge.
    task automatic cycle(input string name, input logic en, input logic ret, input logic call,
                         input logic jmp, input logic br,
                         input logic [7:0] off, input logic [7:0] addr);
        exp_t e;
        bus.en = en; bus.ret = ret; bus.call = call; bus.jump_sel = jmp;
        bus.branch_sel = br; bus.branch_off = off; bus.jump_addr = addr;
        model_step(en, ret, call, jmp, br, off, addr);
        e.pc = pc_m; e.full = m_full(); e.empty = m_empty(); e.err = err_m; e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_txn++;
        $display("txn %0d %s: pc=%h full=%b empty=%b err=%b", n_txn, e.name,
                 bus.pc_out, bus.ras_full, bus.ras_empty, bus.ras_err);
        compare_outputs(e.name, e);
    endtask

    task automatic check_reset_state(input string name);
        exp_t e;
        e.pc = 8'h10; e.full = 1'b0; e.empty = 1'b1; e.err = 1'b0; e.name = name;
        $display("txn %0d %s: pc=%h (async reset)", n_txn, name, bus.pc_out);
        compare_outputs(name, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.en = 0; bus.ret = 0; bus.call = 0; bus.jump_sel = 0;
        bus.branch_sel = 0; bus.branch_off = 0; bus.jump_addr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Free-running increment, then async reset between edges.
        for (int i = 0; i < 3; i++) cycle("incr", 1, 0, 0, 0, 0, 8'h00, 8'h00);
        #2 reset_n = 1'b0;
        #1 check_reset_state("reset_mid");
        model_reset();
        #2 reset_n = 1'b1;

        // Branch wrap forwards and backwards; increment wrap.
        cycle("jmp_fe",   1, 0, 0, 1, 0, 8'h00, 8'hFE);
        cycle("br_fwd",   1, 0, 0, 0, 1, 8'h05, 8'h00);
        cycle("jmp_20",   1, 0, 0, 1, 0, 8'h00, 8'h20);
        cycle("br_back",  1, 0, 0, 0, 1, 8'hF0, 8'h00);
        cycle("jmp_ff",   1, 0, 0, 1, 0, 8'h00, 8'hFF);
        cycle("inc_wrap", 1, 0, 0, 0, 0, 8'h00, 8'h00);
        cycle("stall",    0, 0, 0, 0, 0, 8'h00, 8'h00);

        // Single call/return pair.
        cycle("jmp_30",   1, 0, 0, 1, 0, 8'h00, 8'h30);
        cycle("call_80",  1, 0, 1, 0, 0, 8'h00, 8'h80);
        cycle("ret",      1, 1, 0, 0, 0, 8'h00, 8'h00);

        // Overflow on the fifth call, underflow on the fifth return.
        for (int i = 0; i < 5; i++) cycle("call_n", 1, 0, 1, 0, 0, 8'h00, 8'(8'h40 + 16 * i));
        for (int i = 0; i < 5; i++) cycle("ret_n",  1, 1, 0, 0, 0, 8'h00, 8'h00);

        // Priority with everything asserted, then the same with en low.
        #2 reset_n = 1'b0;
        #1 model_reset();
        #2 reset_n = 1'b1;
        cycle("jmp_43",   1, 0, 0, 1, 0, 8'h00, 8'h43);
        cycle("call_60",  1, 0, 1, 0, 0, 8'h00, 8'h60);
        cycle("all_req",  1, 1, 1, 1, 1, 8'h07, 8'h99);
        cycle("all_stall",0, 1, 1, 1, 1, 8'h07, 8'h99);
        cycle("ret_stall",0, 1, 0, 0, 0, 8'h00, 8'h00);

        // Reset while a call is being presented: it must be discarded.
        bus.en = 1; bus.call = 1; bus.jump_addr = 8'hC0;
        #2 reset_n = 1'b0;
        #1 check_reset_state("reset_call");
        model_reset();
        #2 reset_n = 1'b1;
        cycle("post_rst", 1, 0, 1, 0, 0, 8'h00, 8'h70);

        // Random mix weighted toward stack traffic.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            cycle("rand", (r != 0), r[0] & r[1], r[2] & ~r[1], r[3] & r[1],
                  4'($urandom) > 4'd7, 8'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
